// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Moore-style main control FSM for the multicycle MIPS-subset datapath.
//   Sequences fetch / decode / execute / memory / writeback for R-type, LW,
//   SW, BEQ, J and ADDI. Illegal opcodes trap to a one-cycle EXCEPT state.
//   FETCH, MEM_RD and MEM_WR each hold for MEM_LAT cycles using an internal
//   wait counter.
//
// Parameters
//   STATE_W : width of the state register and state_out (>= 4)
//   MEM_LAT : cycles per memory access (1..15)
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   opcode        in   IR[31:26], sampled only while in DECODE
//   pc_write      out  unconditional PC load
//   pc_write_cond out  PC load qualified externally by ALU zero
//   i_or_d        out  memory address select (0 = PC, 1 = ALUOut)
//   mem_read      out  memory read strobe
//   mem_write     out  memory write strobe
//   ir_write      out  instruction register load
//   mem_to_reg    out  register write data select (1 = MDR, 0 = ALUOut)
//   reg_dst       out  register destination select (1 = rd, 0 = rt)
//   reg_write     out  register file write enable
//   alu_src_a     out  ALU A select (0 = PC, 1 = A)
//   alu_src_b     out  ALU B select (B, 4, sign-ext imm, shifted imm)
//   alu_op        out  ALU operation (00 add, 01 sub, 10 funct)
//   pc_source     out  PC source (ALU, ALUOut, jump target, exc vector)
//   exc_flag      out  high for the single EXCEPT cycle
//   state_out     out  current state code (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int STATE_W = 7,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               exc_flag,
    output logic [STATE_W-1:0] state_out
);

    localparam logic [STATE_W-1:0] S_RESET     = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_FETCH     = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_DECODE    = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEM_ADDR  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEM_RD    = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_MEM_WB    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_MEM_WR    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_R_EXEC    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_R_WB      = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_BRANCH    = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_JUMP      = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_ADDI_EXEC = STATE_W'(12);
    localparam logic [STATE_W-1:0] S_ADDI_WB   = STATE_W'(13);
    localparam logic [STATE_W-1:0] S_EXCEPT    = STATE_W'(14);

    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    logic [STATE_W-1:0] state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               is_load_q, is_load_d;
    logic               cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RESET;
            cnt_q     <= '0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_load_q <= is_load_d;
        end
    end

    // The counter defaults to zero so any state change clears it; it only
    // advances while a memory-holding state is still waiting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        is_load_d = is_load_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (cnt_last) state_d = S_DECODE;
                else          cnt_d   = cnt_q + 4'd1;
            end
            S_DECODE: begin
                // Latch load-vs-store so MEM_ADDR ignores later opcode changes.
                is_load_d = (opcode == OP_LW);
                case (opcode)
                    OP_RTYPE:    state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:      state_d = S_BRANCH;
                    OP_J:        state_d = S_JUMP;
                    OP_ADDI:     state_d = S_ADDI_EXEC;
                    default:     state_d = S_EXCEPT;
                endcase
            end
            S_MEM_ADDR: state_d = is_load_q ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (cnt_last) state_d = S_MEM_WB;
                else          cnt_d   = cnt_q + 4'd1;
            end
            S_MEM_WB: state_d = S_FETCH;
            S_MEM_WR: begin
                if (cnt_last) state_d = S_FETCH;
                else          cnt_d   = cnt_q + 4'd1;
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_EXCEPT:    state_d = S_FETCH;
            default:     state_d = S_RESET;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        exc_flag      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR and PC are loaded only once the read data is valid.
                ir_write  = cnt_last;
                pc_write  = cnt_last;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB: reg_write = 1'b1;
            S_EXCEPT: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
                exc_flag  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl. Three instances run with
//   MEM_LAT = 1, 3 and 4 (the MEM_LAT=3 one with a narrow state register).
//   The expected cycle-by-cycle behaviour of each instruction is generated
//   from the instruction-level description (cycle lists per opcode).
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst [3];
    logic [5:0] opc [3];

    wire [16:0] ob0, ob1, ob2;
    wire [6:0]  so0, so2;
    wire [3:0]  so1;

    int total = 0;
    int bad   = 0;

    int          exp_st[$];
    logic [16:0] exp_o[$];
    int          obs_st[$];
    logic [16:0] obs_o[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl #(.STATE_W(7), .MEM_LAT(1)) u0 (
        .clk(clk), .reset(rst[0]), .opcode(opc[0]),
        .pc_write(ob0[16]), .pc_write_cond(ob0[15]), .i_or_d(ob0[14]),
        .mem_read(ob0[13]), .mem_write(ob0[12]), .ir_write(ob0[11]),
        .mem_to_reg(ob0[10]), .reg_dst(ob0[9]), .reg_write(ob0[8]),
        .alu_src_a(ob0[7]), .alu_src_b(ob0[6:5]), .alu_op(ob0[4:3]),
        .pc_source(ob0[2:1]), .exc_flag(ob0[0]), .state_out(so0));

    multicycle_ctrl #(.STATE_W(4), .MEM_LAT(3)) u1 (
        .clk(clk), .reset(rst[1]), .opcode(opc[1]),
        .pc_write(ob1[16]), .pc_write_cond(ob1[15]), .i_or_d(ob1[14]),
        .mem_read(ob1[13]), .mem_write(ob1[12]), .ir_write(ob1[11]),
        .mem_to_reg(ob1[10]), .reg_dst(ob1[9]), .reg_write(ob1[8]),
        .alu_src_a(ob1[7]), .alu_src_b(ob1[6:5]), .alu_op(ob1[4:3]),
        .pc_source(ob1[2:1]), .exc_flag(ob1[0]), .state_out(so1));

    multicycle_ctrl #(.STATE_W(7), .MEM_LAT(4)) u2 (
        .clk(clk), .reset(rst[2]), .opcode(opc[2]),
        .pc_write(ob2[16]), .pc_write_cond(ob2[15]), .i_or_d(ob2[14]),
        .mem_read(ob2[13]), .mem_write(ob2[12]), .ir_write(ob2[11]),
        .mem_to_reg(ob2[10]), .reg_dst(ob2[9]), .reg_write(ob2[8]),
        .alu_src_a(ob2[7]), .alu_src_b(ob2[6:5]), .alu_op(ob2[4:3]),
        .pc_source(ob2[2:1]), .exc_flag(ob2[0]), .state_out(so2));

    function automatic int lat(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    function automatic logic [16:0] cur_o(input int k);
        return (k == 0) ? ob0 : (k == 1) ? ob1 : ob2;
    endfunction

    function automatic int cur_s(input int k);
        return (k == 0) ? int'(so0) : (k == 1) ? int'(so1) : int'(so2);
    endfunction

    // Output vector in port order: pcw pcwc iord mr mw irw m2r rdst rw asa asb aop psrc exc
    function automatic logic [16:0] ov(input logic pcw, pcwc, iord, mr, mw, irw,
                                       m2r, rdst, rw, asa, input logic [1:0] asb,
                                       aop, psrc, input logic exc);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, exc};
    endfunction

    task automatic push(input int s, input logic [16:0] v);
        exp_st.push_back(s);
        exp_o.push_back(v);
    endtask

    // Instruction-level reference: the list of (state, outputs) cycles one
    // instruction occupies, starting at its first FETCH cycle.
    task automatic model(input int op, input int l);
        for (int c = 0; c < l; c++)
            push(2, ov(c == l-1, 0, 0, 1, 0, c == l-1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
        push(3, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0));
        case (op)
            'h00: begin
                push(8, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0));
                push(9, ov(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0));
            end
            'h23: begin
                push(4, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0));
                for (int c = 0; c < l; c++)
                    push(5, ov(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
                push(6, ov(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
            end
            'h2B: begin
                push(4, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0));
                for (int c = 0; c < l; c++)
                    push(7, ov(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
            end
            'h04: push(10, ov(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0));
            'h02: push(11, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0));
            'h08: begin
                push(12, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0));
                push(13, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
            end
            default: push(14, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 1));
        endcase
    endtask

    // Reset instance k; returns at the negedge of release (DUT in RESET).
    task automatic do_reset(input int k);
        @(negedge clk);
        rst[k] = 1'b1;
        repeat (2) @(negedge clk);
        rst[k] = 1'b0;
    endtask

    // Plays a program on instance k starting in the first FETCH cycle
    // (#1 after an edge). The real opcode is presented only while the model
    // says the DUT is in DECODE; junk < 0 means random opcodes otherwise.
    task automatic play_prog(input int k, input int ops[$], input int junk);
        int n0, n;
        exp_st.delete(); exp_o.delete(); obs_st.delete(); obs_o.delete();
        foreach (ops[i]) begin
            n0 = exp_st.size();
            model(ops[i], lat(k));
            n = exp_st.size() - n0;
            for (int c = 0; c < n; c++) begin
                obs_st.push_back(cur_s(k));
                obs_o.push_back(cur_o(k));
                if (c == lat(k)) opc[k] = 6'(ops[i]);
                else opc[k] = (junk < 0) ? 6'($urandom_range(0, 63)) : 6'(junk);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (cur_s(k) !== 1 || cur_o(k) !== 17'h0) begin
                bad++;
                $display("FAIL reset inst%0d: state=%0d out=%h, want state=1 out=0", k, cur_s(k), cur_o(k));
            end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    endtask

    task automatic test_rtype_l1;
        int q[$];
        do_reset(0);
        total++;
        if (cur_s(0) !== 1 || cur_o(0) !== 17'h0) begin
            bad++;
            $display("FAIL rtype_reset_state: state=%0d out=%h, want state=1 out=0", cur_s(0), cur_o(0));
        end
        @(posedge clk); #1;
        q.push_back('h00);
        play_prog(0, q, -1);
        foreach (exp_st[i]) begin
            total++;
            if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
                bad++;
                $display("FAIL rtype cyc%0d: state=%0d out=%h, want state=%0d out=%h", i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
            end
        end
        total++;
        if (cur_s(0) !== 2) begin
            bad++;
            $display("FAIL rtype_return: state=%0d, want 2", cur_s(0));
        end
    endtask

    task automatic test_lw_l3;
        int q[$];
        do_reset(1);
        @(posedge clk); #1;
        q.push_back('h23);
        play_prog(1, q, -1);
        total++;
        if (exp_st.size() !== 9) begin
            bad++;
            $display("FAIL lw_length: cycles=%0d, want 9", exp_st.size());
        end
        foreach (exp_st[i]) begin
            total++;
            if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
                bad++;
                $display("FAIL lw cyc%0d: state=%0d out=%h, want state=%0d out=%h", i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
            end
        end
        total++;
        if (cur_s(1) !== 2) begin
            bad++;
            $display("FAIL lw_return: state=%0d, want 2", cur_s(1));
        end
    endtask

    task automatic test_sw_beq_illegal(input int k);
        int q[$];
        do_reset(k);
        @(posedge clk); #1;
        q.push_back('h2B); q.push_back('h04); q.push_back('h3F); q.push_back('h08); q.push_back('h02);
        play_prog(k, q, -1);
        foreach (exp_st[i]) begin
            total++;
            if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
                bad++;
                $display("FAIL sw_beq_ill L%0d cyc%0d: state=%0d out=%h, want state=%0d out=%h", lat(k), i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_opcode_change;
        int q[$];
        do_reset(0);
        @(posedge clk); #1;
        // Load decoded, then opcode parks at J for every other cycle.
        q.push_back('h23);
        play_prog(0, q, 'h02);
        foreach (exp_st[i]) begin
            total++;
            if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
                bad++;
                $display("FAIL opcode_change cyc%0d: state=%0d out=%h, want state=%0d out=%h", i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_reset_mid_access;
        int q[$];
        do_reset(2);
        @(posedge clk); #1;
        // FETCH x4, DECODE, MEM_ADDR, MEM_WR #1, then one more edge.
        for (int c = 0; c < 7; c++) begin
            opc[2] = (c == 4) ? 6'h2B : 6'($urandom_range(0, 63));
            @(posedge clk); #1;
        end
        total++;
        if (cur_s(2) !== 7 || cur_o(2)[12] !== 1'b1) begin
            bad++;
            $display("FAIL midreset_pre: state=%0d mem_write=%b, want state=7 mem_write=1", cur_s(2), cur_o(2)[12]);
        end
        #2;
        rst[2] = 1'b1;
        #1;
        total++;
        if (cur_s(2) !== 1 || cur_o(2) !== 17'h0) begin
            bad++;
            $display("FAIL midreset_async: state=%0d out=%h, want state=1 out=0", cur_s(2), cur_o(2));
        end
        @(negedge clk);
        rst[2] = 1'b0;
        @(posedge clk); #1;
        q.push_back('h00);
        play_prog(2, q, -1);
        foreach (exp_st[i]) begin
            total++;
            if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
                bad++;
                $display("FAIL midreset_restart cyc%0d: state=%0d out=%h, want state=%0d out=%h", i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_random(input int k);
        int q[$];
        int legal[6];
        legal = '{'h00, 'h23, 'h2B, 'h04, 'h02, 'h08};
        do_reset(k);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) != 0) q.push_back(legal[$urandom_range(0, 5)]);
            else q.push_back(int'($urandom_range(0, 63)));
        end
        play_prog(k, q, -1);
        foreach (exp_st[i]) begin
            total++;
            if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
                bad++;
                $display("FAIL random L%0d cyc%0d: state=%0d out=%h, want state=%0d out=%h", lat(k), i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            opc[k] = '0;
        end
        test_reset();
        test_rtype_l1();
        test_lw_l3();
        test_sw_beq_illegal(0);
        test_sw_beq_illegal(1);
        test_opcode_change();
        test_reset_mid_access();
        for (int k = 0; k < 3; k++) test_random(k);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
